// File: rtl/sqemux_sel_ctrl.sv
// Select/enable sequencer for one SQEMUX: gates SEN for GAP_CYCLES around every SELECT flip.
// All outputs registered; requests arriving while BUSY are dropped, not queued.
module sqemux_sel_ctrl #(
   parameter int GAP_CYCLES = 4,
   parameter int CNT_W      = 8
) (
   input  logic             QCK,
   input  logic             QRT,
   input  logic             REQ,
   input  logic             REQSEL,
   output logic             SELECT,
   output logic             SEN,
   output logic             DEN,
   output logic             DYNEN,
   output logic             BUSY,
   output logic             DONE,
   output logic [CNT_W-1:0] SWCNT
);

   localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_t;

   state_t           state, next_state;
   logic [3:0]       gap_cnt, gap_cnt_d;
   logic             req_sel, req_sel_d;
   logic             sel_d, sen_d, busy_d, done_d;
   logic [CNT_W-1:0] swcnt_d;

   always_ff @(posedge QCK) begin
      if (QRT) begin
         state   <= IDLE;
         gap_cnt <= 4'd0;
         req_sel <= 1'b0;
      end else begin
         state   <= next_state;
         gap_cnt <= gap_cnt_d;
         req_sel <= req_sel_d;
      end
   end

   always_comb begin
      next_state = state;
      gap_cnt_d  = gap_cnt;
      req_sel_d  = req_sel;
      case (state)
         IDLE: begin
            if (REQ && (REQSEL != SELECT)) begin
               next_state = DRAIN;
               gap_cnt_d  = GAP_LD;
               req_sel_d  = REQSEL;
            end
         end
         DRAIN: begin
            if (gap_cnt == 4'd0) next_state = SWITCH;
            else                 gap_cnt_d  = gap_cnt - 4'd1;
         end
         SWITCH: begin
            next_state = SETTLE;
            gap_cnt_d  = GAP_LD;
         end
         SETTLE: begin
            if (gap_cnt == 4'd0) next_state = IDLE;
            else                 gap_cnt_d  = gap_cnt - 4'd1;
         end
         default: next_state = IDLE;
      endcase
   end

   // The flip is registered on the edge entering SWITCH so SELECT is new while SWITCH is shown.
   always_comb begin
      sel_d   = SELECT;
      swcnt_d = SWCNT;
      if ((state == DRAIN) && (gap_cnt == 4'd0)) begin
         sel_d   = req_sel;
         swcnt_d = SWCNT + CNT_W'(1);
      end
      sen_d  = (next_state == IDLE);
      busy_d = (next_state != IDLE);
      done_d = ((state == IDLE) && REQ && (REQSEL == SELECT)) ||
               ((state == SETTLE) && (gap_cnt == 4'd0));
   end

   always_ff @(posedge QCK) begin
      if (QRT) begin
         SELECT <= 1'b0;
         SEN    <= 1'b1;
         DEN    <= 1'b0;
         DYNEN  <= 1'b1;
         BUSY   <= 1'b0;
         DONE   <= 1'b0;
         SWCNT  <= '0;
      end else begin
         SELECT <= sel_d;
         SEN    <= sen_d;
         DEN    <= 1'b0;
         DYNEN  <= 1'b1;
         BUSY   <= busy_d;
         DONE   <= done_d;
         SWCNT  <= swcnt_d;
      end
   end

endmodule

// File: tb/tb_sqemux_sel_ctrl.sv
// Directed bench for sqemux_sel_ctrl: G=4/CNT_W=8 instance for sequencing, G=2/CNT_W=2 for wrap.
module tb_sqemux_sel_ctrl;

   logic       QCK = 1'b0;
   logic       QRT, REQ, REQSEL;
   logic       SELECT, SEN, DEN, DYNEN, BUSY, DONE;
   logic [7:0] SWCNT;

   logic       req_b, reqsel_b;
   logic       select_b, sen_b, den_b, dynen_b, busy_b, done_b;
   logic [1:0] swcnt_b;
   logic       prev_sel_b;

   int checks   = 0;
   int failures = 0;

   always #5 QCK = ~QCK;

   sqemux_sel_ctrl #(.GAP_CYCLES(4), .CNT_W(8)) dut (
      .QCK(QCK), .QRT(QRT), .REQ(REQ), .REQSEL(REQSEL),
      .SELECT(SELECT), .SEN(SEN), .DEN(DEN), .DYNEN(DYNEN),
      .BUSY(BUSY), .DONE(DONE), .SWCNT(SWCNT)
   );

   sqemux_sel_ctrl #(.GAP_CYCLES(2), .CNT_W(2)) dut_w (
      .QCK(QCK), .QRT(QRT), .REQ(req_b), .REQSEL(reqsel_b),
      .SELECT(select_b), .SEN(sen_b), .DEN(den_b), .DYNEN(dynen_b),
      .BUSY(busy_b), .DONE(done_b), .SWCNT(swcnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge QCK);
      #1;
   endtask

   // Also checks that the wrap instance never shows SEN=1 in a cycle where SELECT just moved.
   task automatic tick_b();
      tick();
      if (select_b !== prev_sel_b) chk("wrap_sen_gated", {31'd0, sen_b}, 32'd0);
      prev_sel_b = select_b;
   endtask

   initial begin
      QRT = 1'b1; REQ = 1'b0; REQSEL = 1'b0;
      req_b = 1'b0; reqsel_b = 1'b0; prev_sel_b = 1'b0;
      tick(); tick();
      chk("rst_select", {31'd0, SELECT}, 32'd0);
      chk("rst_sen",    {31'd0, SEN},    32'd1);
      chk("rst_den",    {31'd0, DEN},    32'd0);
      chk("rst_dynen",  {31'd0, DYNEN},  32'd1);
      chk("rst_busy",   {31'd0, BUSY},   32'd0);
      chk("rst_done",   {31'd0, DONE},   32'd0);
      chk("rst_swcnt",  {24'd0, SWCNT},  32'd0);
      chk("rst_b_sen",  {31'd0, sen_b},  32'd1);

      // Switch 0->1 with a stray REQ (REQSEL=0) sampled at E2 that must be ignored.
      QRT = 1'b0; REQ = 1'b1; REQSEL = 1'b1;
      tick();
      chk("e0_sen",    {31'd0, SEN},    32'd0);
      chk("e0_busy",   {31'd0, BUSY},   32'd1);
      chk("e0_select", {31'd0, SELECT}, 32'd0);
      for (int k = 1; k <= 10; k++) begin
         REQ    = (k == 2);
         REQSEL = (k == 2) ? 1'b0 : 1'b1;
         tick();
         chk($sformatf("sw_select_e%0d", k), {31'd0, SELECT}, (k >= 4) ? 32'd1 : 32'd0);
         chk($sformatf("sw_sen_e%0d", k),    {31'd0, SEN},    (k >= 9) ? 32'd1 : 32'd0);
         chk($sformatf("sw_busy_e%0d", k),   {31'd0, BUSY},   (k < 9)  ? 32'd1 : 32'd0);
         chk($sformatf("sw_done_e%0d", k),   {31'd0, DONE},   (k == 9) ? 32'd1 : 32'd0);
         chk($sformatf("sw_swcnt_e%0d", k),  {24'd0, SWCNT},  (k >= 4) ? 32'd1 : 32'd0);
      end
      REQ = 1'b0;
      chk("sw_den",   {31'd0, DEN},   32'd0);
      chk("sw_dynen", {31'd0, DYNEN}, 32'd1);

      // No-op request: SELECT already 1.
      REQ = 1'b1; REQSEL = 1'b1;
      tick();
      REQ = 1'b0;
      chk("noop_done",   {31'd0, DONE},   32'd1);
      chk("noop_sen",    {31'd0, SEN},    32'd1);
      chk("noop_busy",   {31'd0, BUSY},   32'd0);
      chk("noop_select", {31'd0, SELECT}, 32'd1);
      chk("noop_swcnt",  {24'd0, SWCNT},  32'd1);
      tick();
      chk("noop_done_clr", {31'd0, DONE}, 32'd0);

      // Reset at E3, before the flip.
      QRT = 1'b1; tick(); QRT = 1'b0;
      chk("rst2_select", {31'd0, SELECT}, 32'd0);
      chk("rst2_swcnt",  {24'd0, SWCNT},  32'd0);
      REQ = 1'b1; REQSEL = 1'b1; tick(); REQ = 1'b0;
      tick(); tick();
      QRT = 1'b1; tick(); QRT = 1'b0;
      chk("mid3_select", {31'd0, SELECT}, 32'd0);
      chk("mid3_sen",    {31'd0, SEN},    32'd1);
      chk("mid3_busy",   {31'd0, BUSY},   32'd0);
      chk("mid3_done",   {31'd0, DONE},   32'd0);
      tick();
      chk("mid3_done_after", {31'd0, DONE}, 32'd0);
      chk("mid3_busy_after", {31'd0, BUSY}, 32'd0);

      // Reset at E6, after the flip.
      REQ = 1'b1; REQSEL = 1'b1; tick(); REQ = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      chk("mid6_pre_select", {31'd0, SELECT}, 32'd1);
      chk("mid6_pre_swcnt",  {24'd0, SWCNT},  32'd1);
      QRT = 1'b1; tick(); QRT = 1'b0;
      chk("mid6_select", {31'd0, SELECT}, 32'd0);
      chk("mid6_swcnt",  {24'd0, SWCNT},  32'd0);
      chk("mid6_sen",    {31'd0, SEN},    32'd1);
      chk("mid6_done",   {31'd0, DONE},   32'd0);

      // Back-to-back with REQ held high; second request accepted at E10.
      REQ = 1'b1; REQSEL = 1'b1;
      for (int k = 0; k <= 9; k++) tick();
      chk("b2b_done1",   {31'd0, DONE},   32'd1);
      chk("b2b_sen1",    {31'd0, SEN},    32'd1);
      chk("b2b_busy1",   {31'd0, BUSY},   32'd0);
      chk("b2b_select1", {31'd0, SELECT}, 32'd1);
      chk("b2b_swcnt1",  {24'd0, SWCNT},  32'd1);
      REQSEL = 1'b0;
      tick();
      chk("b2b_start_sen",  {31'd0, SEN},  32'd0);
      chk("b2b_start_busy", {31'd0, BUSY}, 32'd1);
      chk("b2b_start_done", {31'd0, DONE}, 32'd0);
      REQ = 1'b0;
      for (int k = 1; k <= 9; k++) tick();
      chk("b2b_done2",   {31'd0, DONE},   32'd1);
      chk("b2b_select2", {31'd0, SELECT}, 32'd0);
      chk("b2b_swcnt2",  {24'd0, SWCNT},  32'd2);
      tick();
      chk("b2b_done2_clr", {31'd0, DONE}, 32'd0);

      // Reset wins over a simultaneous request.
      REQ = 1'b1; REQSEL = 1'b1; QRT = 1'b1;
      tick();
      QRT = 1'b0; REQ = 1'b0;
      chk("prio_busy",   {31'd0, BUSY},   32'd0);
      chk("prio_sen",    {31'd0, SEN},    32'd1);
      chk("prio_select", {31'd0, SELECT}, 32'd0);
      chk("prio_done",   {31'd0, DONE},   32'd0);

      // Wrap: five alternating switches on the 2-bit counter instance (G=2).
      prev_sel_b = select_b;
      for (int s = 0; s < 5; s++) begin
         req_b = 1'b1; reqsel_b = (s % 2 == 0);
         tick_b();
         req_b = 1'b0;
         for (int k = 1; k <= 5; k++) tick_b();
         chk($sformatf("wrap_swcnt_%0d", s),  {30'd0, swcnt_b},  32'((s + 1) % 4));
         chk($sformatf("wrap_select_%0d", s), {31'd0, select_b}, (s % 2 == 0) ? 32'd1 : 32'd0);
         chk($sformatf("wrap_done_%0d", s),   {31'd0, done_b},   32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
